// File: rtl/hd_timing_gen.sv
// rtl/hd_timing_gen.sv - HD raster timing generator with optional genlock to the PAL frame end
module hd_timing_gen #(
    parameter int PIX_DIV = 2,
    parameter int H_ACT   = 1280,
    parameter int H_FP    = 8,
    parameter int H_SYNC  = 32,
    parameter int H_BP    = 40,
    parameter int V_ACT   = 720,
    parameter int V_FP    = 3,
    parameter int V_SYNC  = 5,
    parameter int V_BP    = 20,
    parameter bit HS_POL  = 1'b1,
    parameter bit VS_POL  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_lock_en,
    input  logic        i_frame_end,
    output logic        o_pix_en,
    output logic        o_hd_clk,
    output logic        o_hd_hsync,
    output logic        o_hd_vsync,
    output logic        o_hd_de,
    output logic [11:0] o_h_pos,
    output logic [10:0] o_v_pos,
    output logic        o_frame_start,
    output logic        o_locked
);

    localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT_W  = 12'(H_ACT);
    localparam logic [11:0] HS_START = 12'(H_ACT + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACT + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT_W  = 11'(V_ACT);
    localparam logic [10:0] VS_START = 11'(V_ACT + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACT + V_FP + V_SYNC);
    localparam logic [3:0]  DIV_LAST = 4'(PIX_DIV - 1);
    localparam logic [3:0]  DIV_HALF = 4'(PIX_DIV / 2);

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SNAP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        pending, pending_nxt;
    logic        snap;
    logic [3:0]  div, div_nxt;
    logic [11:0] h_nxt;
    logic [10:0] v_nxt;
    logic        h_wrap;
    logic        in_bp;
    logic        in_window;

    // The strobe is a registered decode of div, so it lands in the div == 0
    // cycle where o_hd_clk is high; the pixel then advances as the clock falls.
    assign div_nxt   = (div == DIV_LAST) ? 4'd0 : div + 4'd1;
    assign h_wrap    = o_pix_en && (o_h_pos == H_LAST);
    assign in_bp     = (o_v_pos >= VS_END);
    assign in_window = in_bp || (o_v_pos == 11'd0);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        snap        = 1'b0;
        case (state)
            ST_FREE: begin
                if (i_frame_end) begin
                    state_nxt   = ST_WAIT;
                    pending_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                // Only back-porch lines may be cut short, so active video and sync survive.
                if (h_wrap && in_bp && (pending || i_frame_end)) begin
                    snap        = 1'b1;
                    state_nxt   = ST_SNAP;
                    pending_nxt = 1'b0;
                end
            end
            ST_SNAP: begin
                if (i_frame_end && !in_window) begin
                    state_nxt   = ST_WAIT;
                    pending_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt   = ST_FREE;
                pending_nxt = 1'b0;
            end
        endcase
        if (!i_lock_en) begin
            state_nxt   = ST_FREE;
            pending_nxt = 1'b0;
            snap        = 1'b0;
        end
    end

    always_comb begin
        h_nxt = o_h_pos;
        v_nxt = o_v_pos;
        if (o_pix_en) begin
            if (o_h_pos == H_LAST) begin
                h_nxt = 12'd0;
                v_nxt = (snap || (o_v_pos == V_LAST)) ? 11'd0 : o_v_pos + 11'd1;
            end else begin
                h_nxt = o_h_pos + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div           <= 4'd0;
            o_h_pos       <= 12'd0;
            o_v_pos       <= 11'd0;
            o_pix_en      <= 1'b0;
            o_hd_clk      <= 1'b1;
            o_hd_de       <= 1'b0;
            o_hd_hsync    <= ~HS_POL;
            o_hd_vsync    <= ~VS_POL;
            o_frame_start <= 1'b0;
            o_locked      <= 1'b0;
            pending       <= 1'b0;
            state         <= ST_FREE;
        end else begin
            div           <= div_nxt;
            o_h_pos       <= h_nxt;
            o_v_pos       <= v_nxt;
            o_pix_en      <= (div == DIV_LAST);
            o_hd_clk      <= (div_nxt < DIV_HALF);
            o_hd_de       <= (h_nxt < H_ACT_W) && (v_nxt < V_ACT_W);
            o_hd_hsync    <= ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? HS_POL : ~HS_POL;
            o_hd_vsync    <= ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? VS_POL : ~VS_POL;
            o_frame_start <= (div == DIV_LAST) && (h_nxt == 12'd0) && (v_nxt == 11'd0);
            o_locked      <= (state_nxt == ST_SNAP);
            pending       <= pending_nxt;
            state         <= state_nxt;
        end
    end

endmodule
